// File: rtl/wta_fire_ctrl_if.sv
// Bundle of the winner-take-all controller's datapath and handshake signals.
//   master : the side that drives the layer inputs and the report back-pressure
//            (i_enable, i_event, i_nout, i_ready) and observes everything else.
//   slave  : wta_fire_ctrl itself.
// Signal names keep the original controller port names.
interface wta_fire_ctrl_if #(
  parameter int unsigned p_neurons = 8,
  parameter int unsigned p_inputs  = 42,
  parameter int unsigned p_vwidth  = 22,
  parameter int unsigned p_cntw    = 16
);
  logic                          i_enable;
  logic [p_inputs-1:0]           i_event;
  logic [p_inputs-1:0]           o_event;
  logic [p_neurons*p_vwidth-1:0] i_nout;
  logic [p_neurons-1:0]          o_spike;
  logic [2:0]                    o_winner;
  logic                          o_valid;
  logic                          i_ready;
  logic                          o_ovf;
  logic                          o_nrst_n;
  logic                          o_busy;
  logic [p_cntw-1:0]             o_fire_cnt;

  modport master (
    output i_enable, i_event, i_nout, i_ready,
    input  o_event, o_spike, o_winner, o_valid, o_ovf, o_nrst_n, o_busy,
           o_fire_cnt
  );

  modport slave (
    input  i_enable, i_event, i_nout, i_ready,
    output o_event, o_spike, o_winner, o_valid, o_ovf, o_nrst_n, o_busy,
           o_fire_cnt
  );
endinterface

// File: rtl/wta_fire_ctrl.sv
// Winner-take-all firing controller for an 8-neuron spiking layer.
//
// Gates raw input events into the neurons while listening, watches every
// neuron output (non-zero = at/above threshold), picks the largest one
// (lowest index on a tie), emits a one-hot spike, then pulses the
// neuron/synapse clear and holds a refractory period with inputs masked.
// The winner index is reported through a valid/ready handshake.
//
// Ports:
//   i_clk    clock
//   i_rst_n  synchronous active-low reset
//   bus      wta_fire_ctrl_if.slave:
//     i_enable   1 = run, 0 = finish the current sequence then idle
//     i_event    raw input spikes        -> o_event  gated spikes (combinational)
//     i_nout     packed neuron outputs, neuron n in [(n+1)*p_vwidth-1 : n*p_vwidth]
//     o_spike    one-hot fire pulse (one cycle)
//     o_winner / o_valid / i_ready   winner report handshake
//     o_ovf      sticky: a fire happened while the previous report was pending
//     o_nrst_n   active-low clear to neuron/synapse state (p_clr cycles)
//     o_busy     high in FIRE, CLEAR and REFRAC
//     o_fire_cnt saturating count of fires
//
// o_winner is 3 bits wide, so p_neurons must stay 8.
module wta_fire_ctrl #(
  parameter int unsigned p_neurons = 8,
  parameter int unsigned p_inputs  = 42,
  parameter int unsigned p_vwidth  = 22,
  parameter int unsigned p_clr     = 2,
  parameter int unsigned p_refrac  = 16,
  parameter int unsigned p_cntw    = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  wta_fire_ctrl_if.slave bus
);

  // One down-counter serves both the clear and the refractory phases.
  localparam int unsigned c_max = (p_clr > p_refrac) ? p_clr : p_refrac;
  localparam int unsigned c_cw  = $clog2(c_max + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LISTEN,
    ST_FIRE,
    ST_CLEAR,
    ST_REFRAC
  } state_t;

  state_t                state;
  logic [2:0]            win_r;
  logic [c_cw-1:0]       cnt;
  logic [p_neurons-1:0]  spike_r;
  logic [2:0]            winner_r;
  logic                  valid_r;
  logic                  ovf_r;
  logic                  nrst_n_r;
  logic [p_cntw-1:0]     fire_cnt_r;

  // Winner selection
  logic [p_vwidth-1:0]   cur_val;
  logic [p_vwidth-1:0]   best_val;
  logic [2:0]            best_idx;
  logic                  any_cand;

  // Strict '>' while scanning upward keeps the lowest index on a tie.
  always_comb begin
    cur_val  = '0;
    best_val = '0;
    best_idx = '0;
    any_cand = 1'b0;
    for (int unsigned n = 0; n < p_neurons; n++) begin
      cur_val = bus.i_nout[n*p_vwidth +: p_vwidth];
      if ((cur_val != '0) && (!any_cand || (cur_val > best_val))) begin
        best_val = cur_val;
        best_idx = 3'(n);
        any_cand = 1'b1;
      end
    end
  end

  // Controller FSM and registered outputs
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state      <= ST_IDLE;
      win_r      <= '0;
      cnt        <= '0;
      spike_r    <= '0;
      winner_r   <= '0;
      valid_r    <= 1'b0;
      ovf_r      <= 1'b0;
      nrst_n_r   <= 1'b1;
      fire_cnt_r <= '0;
    end else begin
      // Report consumed; a FIRE in the same cycle overrides this below.
      if (valid_r && bus.i_ready) begin
        valid_r <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (bus.i_enable) begin
            state <= ST_LISTEN;
          end
        end

        ST_LISTEN: begin
          if (!bus.i_enable) begin
            state <= ST_IDLE;
          end else if (any_cand) begin
            win_r   <= best_idx;
            // Loaded here so the spike is visible during the FIRE cycle.
            spike_r <= p_neurons'(1) << best_idx;
            state   <= ST_FIRE;
          end
        end

        ST_FIRE: begin
          spike_r <= '0;
          if (fire_cnt_r != '1) begin
            fire_cnt_r <= fire_cnt_r + 1'b1;
          end
          if (!valid_r || bus.i_ready) begin
            winner_r <= win_r;
            valid_r  <= 1'b1;
          end else begin
            ovf_r <= 1'b1;
          end
          nrst_n_r <= 1'b0;
          cnt      <= c_cw'(p_clr - 1);
          state    <= ST_CLEAR;
        end

        ST_CLEAR: begin
          if (cnt == '0) begin
            nrst_n_r <= 1'b1;
            if (p_refrac == 0) begin
              state <= bus.i_enable ? ST_LISTEN : ST_IDLE;
            end else begin
              cnt   <= c_cw'(p_refrac - 1);
              state <= ST_REFRAC;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        ST_REFRAC: begin
          if (cnt == '0) begin
            state <= bus.i_enable ? ST_LISTEN : ST_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.o_event    = ((state == ST_LISTEN) && bus.i_enable) ? bus.i_event : '0;
  assign bus.o_busy     = (state == ST_FIRE) || (state == ST_CLEAR) || (state == ST_REFRAC);
  assign bus.o_spike    = spike_r;
  assign bus.o_winner   = winner_r;
  assign bus.o_valid    = valid_r;
  assign bus.o_ovf      = ovf_r;
  assign bus.o_nrst_n   = nrst_n_r;
  assign bus.o_fire_cnt = fire_cnt_r;

endmodule
